banco_seq: RTL and testbench

BANCO_SEQ -- requirements
Module: banco_seq

---
 rtl/banco_seq.sv | 176 +++++++++++++++++
 tb/tb_banco_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_seq.sv
// Command sequencer for a register bank: latch, write, optional readback.
// Readback (READ/RESP, res_* ports) is built only with BANCO_SEQ_READBACK_EN.
module banco_seq #(
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_x,
    input  logic [DW-1:0] cmd_y,
    input  logic          cmd_c,
    input  logic [2:0]    cmd_dst,
    input  logic [2:0]    cmd_src,
    output logic [DW-1:0] X,
    output logic [DW-1:0] Y,
    output logic          C,
    output logic [2:0]    w_addr,
    output logic          en_addr,
    output logic [2:0]    SEL,
    input  logic [RW-1:0] R,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic          busy,
    output logic [7:0]    cmd_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;
    logic          c_q, c_d;
    logic [2:0]    dst_q, dst_d;
    logic [7:0]    count_q, count_d;
    logic          accept;
    logic          done;

`ifdef BANCO_SEQ_READBACK_EN
    logic [2:0]    src_q, src_d;
    logic [RW-1:0] res_q, res_d;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) state_d = WRITE;
            end
`ifdef BANCO_SEQ_READBACK_EN
            WRITE: state_d = READ;
            READ:  state_d = RESP;
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
`else
            WRITE: state_d = IDLE;
            READ:  state_d = IDLE;
            RESP:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output logic, purely from state so reset clears it at once
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        en_addr   = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            WRITE: en_addr = 1'b1;
`ifdef BANCO_SEQ_READBACK_EN
            RESP: res_valid = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = cmd_valid && (state_q == IDLE);

`ifdef BANCO_SEQ_READBACK_EN
    assign done = (state_q == RESP) && res_ready;
`else
    assign done = (state_q == WRITE);
`endif

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        dst_d   = dst_q;
        count_d = count_q;
        if (accept) begin
            x_d   = cmd_x;
            y_d   = cmd_y;
            c_d   = cmd_c;
            dst_d = cmd_dst;
        end
        if (done) count_d = count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= 1'b0;
            dst_q   <= '0;
            count_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            dst_q   <= dst_d;
            count_q <= count_d;
        end
    end

`ifdef BANCO_SEQ_READBACK_EN
    // res_q only loads in READ, so it is frozen through RESP
    always_comb begin
        src_d = src_q;
        res_d = res_q;
        if (accept) src_d = cmd_src;
        if (state_q == READ) res_d = R;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q <= '0;
            res_q <= '0;
        end else begin
            src_q <= src_d;
            res_q <= res_d;
        end
    end

    assign SEL      = src_q;
    assign res_data = res_q;
`else
    logic unused_rb;
    assign unused_rb = ^{R, res_ready, cmd_src};

    assign SEL      = dst_q;
    assign res_data = '0;
`endif

    assign X         = x_q;
    assign Y         = y_q;
    assign C         = c_q;
    assign w_addr    = dst_q;
    assign cmd_count = count_q;

endmodule

// File: tb/tb_banco_seq.sv
// Directed bench for banco_seq with a small behavioural register bank.
// Works in both builds; readback checks follow BANCO_SEQ_READBACK_EN.
module tb_banco_seq;

    localparam int DW = 8;
    localparam int RW = 16;
`ifdef BANCO_SEQ_READBACK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_x;
    logic [DW-1:0] cmd_y;
    logic          cmd_c;
    logic [2:0]    cmd_dst;
    logic [2:0]    cmd_src;
    logic [DW-1:0] X;
    logic [DW-1:0] Y;
    logic          C;
    logic [2:0]    w_addr;
    logic          en_addr;
    logic [2:0]    SEL;
    logic [RW-1:0] R;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic          busy;
    logic [7:0]    cmd_count;

    banco_seq #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_c     (cmd_c),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .X         (X),
        .Y         (Y),
        .C         (C),
        .w_addr    (w_addr),
        .en_addr   (en_addr),
        .SEL       (SEL),
        .R         (R),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    // Bank model: C=1 stores X+Y, C=0 stores X&Y
    logic [RW-1:0] bank [8];
    initial for (int i = 0; i < 8; i++) bank[i] = '0;
    always @(posedge clk) begin
        if (en_addr) begin
            if (C) bank[w_addr] <= {8'h00, X} + {8'h00, Y};
            else   bank[w_addr] <= {8'h00, X & Y};
        end
    end
    assign R = bank[SEL];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_count;
    int wr_cyc;
    int last_wr;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        c;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left one step after a rising edge with the FSM in IDLE
    task automatic run_cmd(input vec_t v);
        cmd_x     = v.x;
        cmd_y     = v.y;
        cmd_c     = v.c;
        cmd_dst   = v.dst;
        cmd_src   = v.src;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wr_cyc = cyc;
        chk("write_en", en_addr, 1);
        chk("write_addr", w_addr, v.dst);
        chk("write_xy", {X, Y}, {v.x, v.y});
        chk("write_c", C, v.c);
        chk("write_ready", {cmd_ready, busy}, 2'b01);
`ifdef BANCO_SEQ_READBACK_EN
        tick();
        chk("read_sel", SEL, v.src);
        chk("read_en", en_addr, 0);
        chk("read_valid", res_valid, 0);
        tick();
        chk("resp_valid", res_valid, 1);
        chk("resp_data", res_data, v.res);
`endif
        tick();
        exp_count = exp_count + 8'd1;
        chk("idle_ready", {cmd_ready, busy, en_addr}, 3'b100);
        chk("idle_count", cmd_count, exp_count);
        chk("idle_resv", res_valid, 0);
`ifndef BANCO_SEQ_READBACK_EN
        chk("idle_sel", SEL, v.dst);
        chk("idle_resd", res_data, 0);
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_xy"}, {X, Y}, 0);
        chk({tag, "_c_wa"}, {C, w_addr}, 0);
        chk({tag, "_en_sel"}, {en_addr, SEL}, 0);
        chk({tag, "_res"}, {res_valid, res_data}, 0);
        chk({tag, "_count"}, cmd_count, 0);
        chk({tag, "_busy_rdy"}, {busy, cmd_ready}, 2'b01);
    endtask

    initial begin
        vecs[0] = '{8'h0F, 8'hF0, 1'b1, 3'd5, 3'd5, 16'h00FF};
        vecs[1] = '{8'hF0, 8'h55, 1'b0, 3'd4, 3'd4, 16'h0050};
        vecs[2] = '{8'hF0, 8'h55, 1'b1, 3'd2, 3'd4, 16'h0050};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 3'd7, 3'd2, 16'h0145};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 3'd0, 3'd7, 16'h01FE};
        vecs[5] = '{8'h3C, 8'hC3, 1'b0, 3'd1, 3'd0, 16'h0100};

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        cmd_c = 1'b0;
        cmd_dst = '0;
        cmd_src = '0;
        res_ready = 1'b1;
        exp_count = '0;
        last_wr = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b1;
        tick();

        // Back-to-back stream; writes must be LAT cycles apart
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i]);
            if (i > 0) chk("b2b_spacing", wr_cyc - last_wr, LAT);
            last_wr = wr_cyc;
        end

        // Commands offered while busy are not stored
        cmd_x = 8'h11;
        cmd_y = 8'h22;
        cmd_c = 1'b1;
        cmd_dst = 3'd3;
        cmd_src = 3'd3;
        cmd_valid = 1'b1;
`ifdef BANCO_SEQ_READBACK_EN
        res_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 16'h0033);
            chk("bp_ready", cmd_ready, 0);
            if (k == 2) begin
                cmd_dst = 3'd6;
                cmd_x = 8'hAA;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        chk("bp_hold", res_valid, 1);
        res_ready = 1'b1;
        tick();
`else
        res_ready = 1'b0;
        tick();
        chk("ign_write", en_addr, 1);
        cmd_dst = 3'd6;
        cmd_x = 8'hAA;
        tick();
        cmd_valid = 1'b0;
`endif
        exp_count = exp_count + 8'd1;
        chk("ign_done_count", cmd_count, exp_count);
        chk("ign_done_idle", {busy, cmd_ready}, 2'b01);
        tick();
        chk("ign_not_taken", {busy, en_addr}, 0);
        chk("ign_waddr", {w_addr, X}, {3'd3, 8'h11});
        res_ready = 1'b1;

        // Reset in the middle of a command
        cmd_x = 8'h77;
        cmd_y = 8'h01;
        cmd_dst = 3'd6;
        cmd_src = 3'd6;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
`ifdef BANCO_SEQ_READBACK_EN
        tick();
        chk("mid_in_read", {busy, en_addr, SEL}, {1'b1, 1'b0, 3'd6});
`else
        chk("mid_in_write", en_addr, 1);
`endif
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_count = '0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                tick();
                seen = seen | res_valid | busy;
            end
            chk("midrst_quiet", seen, 0);
            chk("midrst_count", cmd_count, 0);
        end

        // 255 back-to-back commands, then one more wraps the counter
        cmd_x = 8'h01;
        cmd_y = 8'h02;
        cmd_dst = 3'd1;
        cmd_src = 3'd1;
        cmd_valid = 1'b1;
        repeat (255 * LAT) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_count = exp_count + 8'd255;
        chk("wrap_255", cmd_count, exp_count);
        chk("wrap_idle", busy, 0);
        run_cmd(vecs[0]);
        chk("wrap_zero", cmd_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
